axi_line_memory_responder: RTL and testbench
============================================

Name: axi_line_memory_responder

Overview:
- AXI-style memory responder (slave) for the cache bus master. Serves cache-line burst reads (AR/R) and writes (AW/W/B) from an internal word array.
- Acts as the memory end of the bus in system simulation and FPGA bring-up.
- Handles one transaction at a time. Supports FIXED, INCR and WRAP bursts. Only 8-byte beats are supported.

Parameters:
- DATA_WIDTH, 64, beat width in bits; fixed at 64.
- ADDR_WIDTH, 64, byte-address width.
- DEPTH, 1024, number of DATA_WIDTH words in the array; power of two.
- BASE_ADDR, 0, byte address of word 0.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- s_axi_araddr  in  ADDR_WIDTH  read start byte address
- s_axi_arlen  in  8  beats-1
- s_axi_arsize  in  3  beat size; treated as 3'b011 regardless
- s_axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address accepted
- s_axi_rdata  out  DATA_WIDTH  read beat
- s_axi_rresp  out  2  00 OKAY, 10 SLVERR
- s_axi_rlast  out  1  final read beat
- s_axi_rvalid  out  1  read beat valid
- s_axi_rready  in  1  master accepts beat
- s_axi_awaddr / awlen / awsize / awburst / awvalid  in  as AR  write address channel
- s_axi_awready  out  1  write address accepted
- s_axi_wdata  in  DATA_WIDTH  write beat
- s_axi_wlast  in  1  final write beat (from master)
- s_axi_wvalid  in  1  write beat valid
- s_axi_wready  out  1  write beat accepted
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  response valid
- s_axi_bready  in  1  master accepts response

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high.
- Reset values: state=IDLE; all outputs 0 (arready, awready, rvalid, rlast, rresp, rdata, wready, bvalid, bresp). Array contents are not reset.
- Reset asserted mid-burst aborts the transaction next edge; no further beats or B are issued.
- FSM states: IDLE, R_BURST, W_BURST, W_RESP.
- IDLE:
  - arready=awready=1 combinationally.
  - If arvalid: latch AR fields and go to R_BURST. Read wins when arvalid and awvalid arrive in the same cycle.
  - Otherwise, if awvalid: latch AW fields and go to W_BURST.
  - Only the winning ready is asserted; the loser's ready is 0 that cycle.
- Beat address, with start word index s = (addr-BASE_ADDR)>>3 and beat counter k:
  - FIXED: s.
  - INCR: s+k.
  - WRAP: (s & ~(len)) | ((s+k) & len). Applies only when len+1 is 2, 4, 8 or 16; any other len is treated as INCR.
- Out-of-range beat:
  - A beat is out of range if its index is >= DEPTH or its addr is < BASE_ADDR.
  - Read: rdata=0, rresp=SLVERR.
  - Write: data discarded; the final bresp is SLVERR if any beat was out of range.
- R_BURST:
  - rvalid=1 from the cycle after the AR handshake, i.e. first-beat latency is 1 cycle.
  - rdata and rresp are registered for the current beat and held stable while rready=0.
  - On rvalid&&rready: k++ and the next beat is presented the next cycle with no bubble.
  - rlast=1 exactly when k==len.
  - The handshake on the last beat returns to IDLE.
- W_BURST:
  - wready=1. Each wvalid&&wready writes wdata to the beat address and increments k.
  - The burst ends on the beat where k==len, regardless of wlast.
  - If wlast and k==len disagree, the response is SLVERR and the burst still ends at k==len.
  - Then go to W_RESP.
- W_RESP: bvalid=1 with bresp held until bready; then IDLE.
- A write followed by a read of the same address returns the new data; the array write completes before the AR can be accepted.
- The beat counter is 8 bits; len=255 wraps correctly to completion.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0 during reset; arready=awready=1 in IDLE after deassert.
- INCR write, awaddr=0x40, awlen=7, wdata=0x100..0x107, bready=1 -> words 8..15 written; bvalid one cycle after last beat with bresp=00.
- WRAP read, araddr=0x58, arlen=7, rready=1 -> rdata order = words 11,12,13,14,15,8,9,10 (0x103..0x107,0x100..0x102); rlast only on the 8th beat; rresp=00.
- Same read with rready toggling 1,0,1,0 -> each beat held stable while rready=0; still 8 beats in the same order.
- arvalid and awvalid in the same IDLE cycle -> arready=1, awready=0; read completes; AW accepted in the next IDLE.
- Read at BASE_ADDR+DEPTH*8-8 with INCR len=1 -> beat0 OKAY with data; beat1 rdata=0, rresp=10.
- Write with wlast asserted on beat 2 of len=3 -> 4 beats accepted; bresp=10.

Source files
------------

// File: rtl/axi_line_memory_responder.sv
// Single-transaction AXI-style memory responder serving FIXED/INCR/WRAP bursts of
// 8-byte beats from an internal word array; reads and writes share one beat counter.
module axi_line_memory_responder #(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready
);

  localparam int                    IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_W = ADDR_WIDTH'(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_R_BURST = 2'd1;
  localparam logic [1:0] S_W_BURST = 2'd2;
  localparam logic [1:0] S_W_RESP  = 2'd3;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_start;
  logic                  r_base_ok;
  logic [7:0]            r_len;
  logic [7:0]            r_k;
  logic [1:0]            r_burst;
  logic                  r_w_err;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  r_rvalid;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // WRAP only wraps for 2/4/8/16-beat bursts; other lengths fall back to INCR.
  function automatic logic [ADDR_WIDTH-1:0] beat_index(
    input logic [ADDR_WIDTH-1:0] start,
    input logic [7:0]            k,
    input logic [7:0]            len,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] len_x;
    logic [ADDR_WIDTH-1:0] sum;
    logic                  wrap_ok;
    len_x   = ADDR_WIDTH'(len);
    sum     = start + ADDR_WIDTH'(k);
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    if (burst == BURST_FIXED)                 return start;
    else if (burst == BURST_WRAP && wrap_ok)  return (start & ~len_x) | (sum & len_x);
    else                                      return sum;
  endfunction

  logic                  w_unused;
  logic                  w_idle;
  logic                  w_ar_base_ok, w_aw_base_ok;
  logic [ADDR_WIDTH-1:0] w_ar_start, w_aw_start;
  logic [ADDR_WIDTH-1:0] w_ar_idx, w_r_next_idx, w_w_idx;
  logic [7:0]            w_r_next_k;
  logic                  w_ar_oob, w_r_next_oob, w_w_oob;
  logic                  w_ar_hs, w_aw_hs, w_r_hs, w_w_hs;
  logic                  w_last_beat, w_w_bad, w_mem_we;

  assign w_unused = ^{s_axi_arsize, s_axi_awsize};

  assign w_ar_base_ok = (s_axi_araddr >= BASE_ADDR);
  assign w_aw_base_ok = (s_axi_awaddr >= BASE_ADDR);
  assign w_ar_start   = (s_axi_araddr - BASE_ADDR) >> 3;
  assign w_aw_start   = (s_axi_awaddr - BASE_ADDR) >> 3;

  assign w_ar_idx     = beat_index(w_ar_start, 8'd0, s_axi_arlen, s_axi_arburst);
  assign w_r_next_k   = r_k + 8'd1;
  assign w_r_next_idx = beat_index(r_start, w_r_next_k, r_len, r_burst);
  assign w_w_idx      = beat_index(r_start, r_k, r_len, r_burst);

  assign w_ar_oob     = !w_ar_base_ok || (w_ar_idx >= DEPTH_W);
  assign w_r_next_oob = !r_base_ok || (w_r_next_idx >= DEPTH_W);
  assign w_w_oob      = !r_base_ok || (w_w_idx >= DEPTH_W);

  // Read wins a simultaneous request, so AW is only offered when AR is idle.
  assign w_idle        = (r_state == S_IDLE) && !reset;
  assign s_axi_arready = w_idle;
  assign s_axi_awready = w_idle && !s_axi_arvalid;
  assign s_axi_wready  = (r_state == S_W_BURST) && !reset;

  assign w_ar_hs     = s_axi_arvalid && s_axi_arready;
  assign w_aw_hs     = s_axi_awvalid && s_axi_awready;
  assign w_r_hs      = r_rvalid && s_axi_rready;
  assign w_w_hs      = s_axi_wvalid && s_axi_wready;
  assign w_last_beat = (r_k == r_len);
  assign w_w_bad     = w_w_oob || (s_axi_wlast != w_last_beat);
  assign w_mem_we    = w_w_hs && !w_w_oob;

  assign s_axi_rdata  = r_rdata;
  assign s_axi_rresp  = r_rresp;
  assign s_axi_rvalid = r_rvalid;
  assign s_axi_rlast  = r_rvalid && w_last_beat;
  assign s_axi_bvalid = r_bvalid;
  assign s_axi_bresp  = r_bresp;

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_start   <= '0;
      r_base_ok <= 1'b0;
      r_len     <= '0;
      r_k       <= '0;
      r_burst   <= BURST_FIXED;
      r_w_err   <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_rvalid  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ar_hs) begin
            r_state   <= S_R_BURST;
            r_start   <= w_ar_start;
            r_base_ok <= w_ar_base_ok;
            r_len     <= s_axi_arlen;
            r_burst   <= s_axi_arburst;
            r_k       <= '0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_ar_oob ? '0 : r_mem[w_ar_idx[IDX_W-1:0]];
            r_rresp   <= w_ar_oob ? RESP_SLVERR : RESP_OKAY;
          end else if (w_aw_hs) begin
            r_state   <= S_W_BURST;
            r_start   <= w_aw_start;
            r_base_ok <= w_aw_base_ok;
            r_len     <= s_axi_awlen;
            r_burst   <= s_axi_awburst;
            r_k       <= '0;
            r_w_err   <= 1'b0;
          end
        end
        S_R_BURST: begin
          if (w_r_hs) begin
            if (w_last_beat) begin
              r_state  <= S_IDLE;
              r_rvalid <= 1'b0;
              r_rdata  <= '0;
              r_rresp  <= RESP_OKAY;
            end else begin
              r_k     <= w_r_next_k;
              r_rdata <= w_r_next_oob ? '0 : r_mem[w_r_next_idx[IDX_W-1:0]];
              r_rresp <= w_r_next_oob ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        S_W_BURST: begin
          if (w_w_hs) begin
            r_k     <= r_k + 8'd1;
            r_w_err <= r_w_err || w_w_bad;
            if (w_last_beat) begin
              r_state  <= S_W_RESP;
              r_bvalid <= 1'b1;
              r_bresp  <= (r_w_err || w_w_bad) ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        default: begin
          if (s_axi_bready) begin
            r_state  <= S_IDLE;
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
          end
        end
      endcase
    end
  end

  // NOTE: the word array is deliberately left out of reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_w_idx[IDX_W-1:0]] <= s_axi_wdata;
  end

endmodule

// File: tb/tb_axi_line_memory_responder.sv
// Bench for axi_line_memory_responder: directed vector table, hand-written corner
// sequences and random bursts checked against an array-based memory model.
module tb_axi_line_memory_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [63:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [63:0] s_axi_wdata;
  logic        s_axi_wlast;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;

  always #5 clk = ~clk;

  axi_line_memory_responder dut (
    .clk(clk), .reset(reset),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready)
  );

  typedef struct {
    bit          is_wr;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    int          mode;       // read: rready pattern; write: beat carrying wlast (-1 = last beat)
    logic [63:0] data0;      // write data base (data0+k); 0 = random data
    logic [1:0]  exp_resp;   // write: bresp; read: rresp of final beat
    bit          chk_first;
    logic [63:0] exp_first;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] ref_mem [DEPTH];
  logic [63:0] wbuf [256];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: DUT did not respond within the cycle budget", name);
  endtask

  // Word index of beat k, straight from the burst rules (BASE_ADDR is 0 here).
  function automatic longint model_idx(input logic [63:0] addr, input logic [7:0] len,
                                       input logic [1:0] burst, input int k);
    longint start;
    longint n;
    start = longint'(addr >> 3);
    n     = longint'(len) + 1;
    if (burst == 2'b00) return start;
    if (burst == 2'b10 && (n == 2 || n == 4 || n == 8 || n == 16))
      return (start / n) * n + (start + k) % n;
    return start + k;
  endfunction

  task automatic ar_phase(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst);
    int t = 0;
    @(negedge clk);
    s_axi_araddr = addr; s_axi_arlen = len; s_axi_arburst = burst;
    s_axi_arsize = 3'($urandom); s_axi_arvalid = 1'b1;
    #1;
    while (s_axi_arready !== 1'b1 && t < 50) begin @(negedge clk); #1; t++; end
    check("ar_accept", s_axi_arready, 1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
  endtask

  task automatic aw_phase(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst);
    int t = 0;
    @(negedge clk);
    s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awburst = burst;
    s_axi_awsize = 3'($urandom); s_axi_awvalid = 1'b1;
    #1;
    while (s_axi_awready !== 1'b1 && t < 50) begin @(negedge clk); #1; t++; end
    check("aw_accept", s_axi_awready, 1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
  endtask

  // Starts at the negedge after the AR handshake; every cycle is checked against beat k.
  task automatic read_beats(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input int rmode, output logic [63:0] first_data, output logic [1:0] last_resp);
    int          k = 0;
    int          cyc = 0;
    logic        rr;
    longint      idx;
    logic [63:0] ed;
    logic [1:0]  er;
    first_data = 'x;
    last_resp  = 'x;
    while (k <= int'(len)) begin
      if (cyc > 1100) begin timeout("r_beats"); break; end
      case (rmode)
        0:       rr = 1'b1;
        1:       rr = (cyc % 2 == 0);
        default: rr = 1'($urandom_range(0, 1));
      endcase
      s_axi_rready = rr;
      #1;
      check("rvalid", s_axi_rvalid, 1);
      if (s_axi_rvalid !== 1'b1) break;
      idx = model_idx(addr, len, burst, k);
      if (idx < DEPTH) begin ed = ref_mem[idx]; er = 2'b00; end
      else             begin ed = 64'h0;        er = 2'b10; end
      check($sformatf("rdata_k%0d", k), s_axi_rdata, ed);
      check($sformatf("rresp_k%0d", k), s_axi_rresp, er);
      check($sformatf("rlast_k%0d", k), s_axi_rlast, 64'(k == int'(len)));
      if (k == 0) first_data = s_axi_rdata;
      last_resp = s_axi_rresp;
      if (rr) k++;
      @(negedge clk);
      cyc++;
    end
    s_axi_rready = 1'b0;
    #1;
    check("rvalid_end", s_axi_rvalid, 0);
  endtask

  // Starts at the negedge after the AW handshake; data comes from wbuf[k].
  task automatic write_beats(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input int wlast_beat, input int wmode, input int bmode,
                             output logic [1:0] bresp);
    int         k = 0;
    int         cyc = 0;
    int         d;
    logic       wv;
    bit         err = 1'b0;
    bit         to = 1'b0;
    longint     idx;
    logic [1:0] eb;
    bresp = 'x;
    while (k <= int'(len)) begin
      if (cyc > 2000) begin timeout("w_beats"); to = 1'b1; break; end
      wv = (wmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      s_axi_wvalid = wv;
      s_axi_wdata  = wbuf[k];
      s_axi_wlast  = (wlast_beat < 0) ? (k == int'(len)) : (k == wlast_beat);
      #1;
      if (wv && s_axi_wready) begin
        idx = model_idx(addr, len, burst, k);
        if (idx < DEPTH) ref_mem[idx] = wbuf[k];
        else             err = 1'b1;
        if (s_axi_wlast != (k == int'(len))) err = 1'b1;
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    if (!to) begin
      eb = err ? 2'b10 : 2'b00;
      #1;
      check("b_latency", s_axi_bvalid, 1);
      d = (bmode == 0) ? 0 : $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
        s_axi_bready = 1'b0;
        check("bresp_hold", s_axi_bresp, eb);
        @(negedge clk);
        #1;
        check("bvalid_hold", s_axi_bvalid, 1);
      end
      s_axi_bready = 1'b1;
      check("bresp", s_axi_bresp, eb);
      bresp = s_axi_bresp;
      @(negedge clk);
      s_axi_bready = 1'b0;
      #1;
      check("bvalid_end", s_axi_bvalid, 0);
    end
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input int rmode, output logic [63:0] fd, output logic [1:0] lr);
    ar_phase(addr, len, burst);
    read_beats(addr, len, burst, rmode, fd, lr);
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input int wlast_beat, input int wmode, input int bmode, output logic [1:0] bresp);
    aw_phase(addr, len, burst);
    write_beats(addr, len, burst, wlast_beat, wmode, bmode, bresp);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [13];
    logic [63:0] fd;
    logic [1:0]  lr;
    logic [1:0]  resp;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    int          word;
    int          wl;

    vecs[0]  = '{1'b1, 64'h40,   8'd7, 2'b01, -1, 64'h100, 2'b00, 1'b0, 64'h0};
    vecs[1]  = '{1'b0, 64'h58,   8'd7, 2'b10,  0, 64'h0,   2'b00, 1'b1, 64'h103};
    vecs[2]  = '{1'b0, 64'h58,   8'd7, 2'b10,  1, 64'h0,   2'b00, 1'b1, 64'h103};
    vecs[3]  = '{1'b0, 64'h1FF8, 8'd1, 2'b01,  0, 64'h0,   2'b10, 1'b0, 64'h0};
    vecs[4]  = '{1'b1, 64'h200,  8'd3, 2'b01,  2, 64'h200, 2'b10, 1'b0, 64'h0};
    vecs[5]  = '{1'b0, 64'h200,  8'd3, 2'b01,  0, 64'h0,   2'b00, 1'b1, 64'h200};
    vecs[6]  = '{1'b1, 64'h300,  8'd3, 2'b00, -1, 64'h300, 2'b00, 1'b0, 64'h0};
    vecs[7]  = '{1'b0, 64'h300,  8'd2, 2'b00,  2, 64'h0,   2'b00, 1'b1, 64'h303};
    vecs[8]  = '{1'b1, 64'h1FF0, 8'd2, 2'b01, -1, 64'h500, 2'b10, 1'b0, 64'h0};
    vecs[9]  = '{1'b0, 64'h68,   8'd5, 2'b10,  2, 64'h0,   2'b00, 1'b1, 64'h105};
    vecs[10] = '{1'b0, 64'h0,    8'd0, 2'b01,  0, 64'h0,   2'b00, 1'b0, 64'h0};
    vecs[11] = '{1'b1, 64'h84,   8'd3, 2'b10, -1, 64'h700, 2'b00, 1'b0, 64'h0};
    vecs[12] = '{1'b0, 64'h98,   8'd3, 2'b10,  0, 64'h0,   2'b00, 1'b1, 64'h703};

    reset = 1'b1;
    s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'b011; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b0;
    s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'b011; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b0;
    s_axi_rready = 1'b0; s_axi_wdata = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_arready", s_axi_arready, 0);
    check("rst_awready", s_axi_awready, 0);
    check("rst_rvalid",  s_axi_rvalid,  0);
    check("rst_rlast",   s_axi_rlast,   0);
    check("rst_rresp",   s_axi_rresp,   0);
    check("rst_rdata",   s_axi_rdata,   0);
    check("rst_wready",  s_axi_wready,  0);
    check("rst_bvalid",  s_axi_bvalid,  0);
    check("rst_bresp",   s_axi_bresp,   0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("idle_arready", s_axi_arready, 1);
    check("idle_awready", s_axi_awready, 1);
    check("idle_rvalid",  s_axi_rvalid,  0);
    check("idle_bvalid",  s_axi_bvalid,  0);

    // Fill the whole array with len=255 bursts so every later read has a known model value.
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 256; k++) wbuf[k] = {$urandom, $urandom};
      do_write(64'(b) * 64'd2048, 8'd255, 2'b01, -1, 0, 0, resp);
      check("prefill_bresp", resp, 0);
    end
    do_read(64'h0, 8'd255, 2'b01, 2, fd, lr);
    check("len255_last_resp", lr, 0);

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        for (int k = 0; k < 256; k++)
          wbuf[k] = (vecs[i].data0 != 0) ? vecs[i].data0 + 64'(k) : {$urandom, $urandom};
        do_write(vecs[i].addr, vecs[i].len, vecs[i].burst, vecs[i].mode, 0, 0, resp);
        check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
      end else begin
        do_read(vecs[i].addr, vecs[i].len, vecs[i].burst, vecs[i].mode, fd, lr);
        check($sformatf("vec%0d_last_rresp", i), lr, vecs[i].exp_resp);
        if (vecs[i].chk_first) check($sformatf("vec%0d_first_rdata", i), fd, vecs[i].exp_first);
      end
    end

    // Simultaneous AR and AW: read wins, write is taken in the following IDLE cycle.
    @(negedge clk);
    s_axi_araddr = 64'h58;  s_axi_arlen = 8'd7; s_axi_arburst = 2'b10; s_axi_arvalid = 1'b1;
    s_axi_awaddr = 64'h400; s_axi_awlen = 8'd1; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
    #1;
    check("arb_arready", s_axi_arready, 1);
    check("arb_awready", s_axi_awready, 0);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    #1;
    check("arb_awready_busy", s_axi_awready, 0);
    read_beats(64'h58, 8'd7, 2'b10, 0, fd, lr);
    check("arb_first_rdata", fd, 64'h103);
    check("arb_aw_accept", s_axi_awready, 1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    wbuf[0] = 64'hA000; wbuf[1] = 64'hA001;
    write_beats(64'h400, 8'd1, 2'b01, -1, 0, 0, resp);
    check("arb_bresp", resp, 0);
    do_read(64'h400, 8'd1, 2'b01, 0, fd, lr);
    check("arb_readback", fd, 64'hA000);

    // Reset in the middle of a read burst: no further beats.
    ar_phase(64'h0, 8'd7, 2'b01);
    s_axi_rready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    s_axi_rready = 1'b0;
    @(negedge clk);
    #1;
    check("abort_r_rvalid", s_axi_rvalid, 0);
    check("abort_r_arready", s_axi_arready, 0);
    reset = 1'b0;
    s_axi_rready = 1'b1;
    for (int i = 0; i < 3; i++) begin @(negedge clk); #1; check("abort_r_quiet", s_axi_rvalid, 0); end
    s_axi_rready = 1'b0;

    // Reset in the middle of a write burst: beats already taken stay, no B, no write during reset.
    aw_phase(64'h800, 8'd7, 2'b01);
    for (int k = 0; k < 2; k++) begin
      s_axi_wvalid = 1'b1; s_axi_wdata = 64'hDEAD0000 + 64'(k); s_axi_wlast = 1'b0;
      #1;
      check("abort_w_wready", s_axi_wready, 1);
      if (s_axi_wready) ref_mem[256 + k] = s_axi_wdata;
      @(negedge clk);
    end
    s_axi_wdata = 64'hDEAD0002;
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("abort_w_wready_rst", s_axi_wready, 0);
    check("abort_w_bvalid_rst", s_axi_bvalid, 0);
    reset = 1'b0;
    s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b1;
    for (int i = 0; i < 3; i++) begin @(negedge clk); #1; check("abort_w_quiet", s_axi_bvalid, 0); end
    s_axi_bready = 1'b0;
    do_read(64'h800, 8'd3, 2'b01, 0, fd, lr);

    // Random bursts against the model.
    for (int t = 0; t < 60; t++) begin
      word  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1000, 1100)) : int'($urandom_range(0, 1023));
      addr  = 64'(word) * 64'd8 + (($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 7)) : 64'd0);
      len   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      burst = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 256; k++) wbuf[k] = {$urandom, $urandom};
        wl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(len))) : -1;
        do_write(addr, len, burst, wl, 1, 1, resp);
      end else begin
        do_read(addr, len, burst, 2, fd, lr);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
